// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of
// a single-port byte RAM with combinational read data.
module cache_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 11,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  cpu_hit,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESPOND} state_t;

  state_t                  state, state_next;
  logic                    lat_wr;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_din;
  logic [OFFSET_BITS-1:0]  count;
  logic [LINES-1:0]        valid;
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [LINES*WORDS];

  logic [TAG_BITS-1:0]     lat_tag;
  logic [INDEX_BITS-1:0]   lat_index;
  logic [OFFSET_BITS-1:0]  lat_offset;
  logic                    hit;
  logic                    refill_last;

  assign {lat_tag, lat_index, lat_offset} = lat_addr;
  assign hit         = valid[lat_index] && (tag_mem[lat_index] == lat_tag);
  assign refill_last = (count == {OFFSET_BITS{1'b1}});

  // NOTE: every output is given a default first so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    cpu_ready  = 1'b0;
    cpu_done   = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    mem_wr     = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (lat_wr)   state_next = WRITE;
        else if (hit) state_next = RESPOND;
        else          state_next = REFILL;
      end
      REFILL: begin
        mem_addr = {lat_tag, lat_index, count};
        if (refill_last) state_next = RESPOND;
      end
      WRITE: begin
        mem_addr   = lat_addr;
        mem_din    = lat_din;
        mem_wr     = 1'b1;
        state_next = RESPOND;
      end
      RESPOND: begin
        cpu_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      count    <= '0;
      cpu_dout <= '0;
      cpu_hit  <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            lat_wr   <= cpu_wr;
            lat_addr <= cpu_addr;
            lat_din  <= cpu_din;
          end
        end
        LOOKUP: begin
          count   <= '0;
          cpu_hit <= hit;
          if (!lat_wr && hit) cpu_dout <= data_mem[{lat_index, lat_offset}];
        end
        REFILL: begin
          count <= count + 1'b1;
          if (count == lat_offset) cpu_dout <= mem_dout;
          if (refill_last) begin
            valid[lat_index] <= 1'b1;
            cpu_hit          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (state == REFILL) begin
      data_mem[{lat_index, count}] <= mem_dout;
      if (refill_last) tag_mem[lat_index] <= lat_tag;
    end else if (state == WRITE && hit) begin
      data_mem[{lat_index, lat_offset}] <= lat_din;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural byte RAM (ram[a] = a+10 at start).
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ready, cpu_done, cpu_hit;
  logic [7:0]  cpu_dout;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr;

  logic [7:0]  ram [2048];

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent request.
  int r_lat, r_dout, r_hit, r_pulses, r_wr_addr, r_wr_din, r_dones;
  int r_addr [13];

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_dout  (cpu_dout),
    .cpu_hit   (cpu_hit),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout)
  );

  assign mem_dout = ram[mem_addr];
  always @(posedge clk) if (mem_wr) ram[mem_addr] <= mem_din;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed,
             expected, expected);
    end
  endtask

  // Issue one request and watch 12 cycles after the acceptance edge. glitch_at > 0
  // raises cpu_req (addr 8) for the edge ending that cycle.
  task automatic do_req(input logic wr, input logic [10:0] addr, input logic [7:0] din,
                        input int glitch_at);
    r_lat = -1; r_dout = -1; r_hit = -1; r_pulses = 0; r_dones = 0;
    r_wr_addr = -1; r_wr_din = -1;
    @(negedge clk);
    check("ready_before_req", int'(cpu_ready), 1);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_din = din;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      r_addr[c] = int'(mem_addr);
      if (mem_wr) begin
        r_pulses++;
        r_wr_addr = int'(mem_addr);
        r_wr_din  = int'(mem_din);
      end
      if (cpu_done) begin
        r_dones++;
        if (r_lat < 0) begin
          r_lat  = c;
          r_dout = int'(cpu_dout);
          r_hit  = int'(cpu_hit);
        end
      end
      cpu_req = (c == glitch_at);
      cpu_wr  = 1'b0;
      if (c == glitch_at) cpu_addr = 11'd8;
    end
  endtask

  task automatic expect_read(input string tag, input int lat, input int dout, input int hit);
    check({tag, "_latency"}, r_lat, lat);
    check({tag, "_dout"}, r_dout, dout);
    check({tag, "_hit"}, r_hit, hit);
    check({tag, "_dones"}, r_dones, 1);
    check({tag, "_no_mem_wr"}, r_pulses, 0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = 8'(a + 10);
    reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
    #12;
    check("rst_ready", int'(cpu_ready), 1);
    check("rst_done", int'(cpu_done), 0);
    check("rst_hit", int'(cpu_hit), 0);
    check("rst_dout", int'(cpu_dout), 0);
    check("rst_mem_wr", int'(mem_wr), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_din", int'(mem_din), 0);
    @(negedge clk);
    reset = 1'b0;

    // Cold read miss: refill sweeps the whole line 4..7.
    do_req(1'b0, 11'd5, 8'h00, 0);
    expect_read("rd5_miss", 6, 15, 0);
    check("rd5_lookup_addr", r_addr[1], 0);
    for (int k = 0; k < 4; k++) check($sformatf("rd5_sweep%0d", k), r_addr[2 + k], 4 + k);
    check("rd5_respond_addr", r_addr[6], 0);

    do_req(1'b0, 11'd6, 8'h00, 0);
    expect_read("rd6_hit", 2, 16, 1);

    // Write hit: write-through plus cached copy updated.
    do_req(1'b1, 11'd5, 8'hAA, 0);
    check("wr5_latency", r_lat, 3);
    check("wr5_hit", r_hit, 1);
    check("wr5_pulses", r_pulses, 1);
    check("wr5_mem_addr", r_wr_addr, 5);
    check("wr5_mem_din", r_wr_din, 8'hAA);
    check("wr5_dones", r_dones, 1);
    do_req(1'b0, 11'd5, 8'h00, 0);
    expect_read("rd5_after_wr", 2, 8'hAA, 1);
    check("ram5", int'(ram[5]), 8'hAA);

    // Conflicts on index 1 (addresses 5 and 37).
    do_req(1'b0, 11'd37, 8'h00, 0);
    expect_read("rd37_miss", 6, 47, 0);
    do_req(1'b0, 11'd5, 8'h00, 0);
    expect_read("rd5_evicted", 6, 8'hAA, 0);
    do_req(1'b0, 11'd37, 8'h00, 0);
    expect_read("rd37_again", 6, 47, 0);

    // Write miss: RAM written, no allocate.
    do_req(1'b1, 11'd40, 8'h55, 0);
    check("wr40_latency", r_lat, 3);
    check("wr40_hit", r_hit, 0);
    check("wr40_pulses", r_pulses, 1);
    check("wr40_mem_addr", r_wr_addr, 40);
    check("wr40_mem_din", r_wr_din, 8'h55);
    do_req(1'b0, 11'd40, 8'h00, 0);
    expect_read("rd40_miss", 6, 8'h55, 0);

    // Reset in the 2nd REFILL cycle of a read of 20.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'd20;
    @(posedge clk);
    @(negedge clk); cpu_req = 1'b0;  // LOOKUP
    @(negedge clk);                  // REFILL word 0
    @(negedge clk);                  // REFILL word 1
    check("abort_in_refill_addr", int'(mem_addr), 21);
    reset = 1'b1;
    #1;
    check("abort_ready", int'(cpu_ready), 1);
    check("abort_done", int'(cpu_done), 0);
    check("abort_mem_addr", int'(mem_addr), 0);
    r_dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) reset = 1'b0;
      if (cpu_done) r_dones++;
    end
    check("abort_no_done", r_dones, 0);
    do_req(1'b0, 11'd20, 8'h00, 0);
    expect_read("rd20_after_abort", 6, 30, 0);

    // Request pulsed during REFILL is ignored.
    do_req(1'b0, 11'd44, 8'h00, 3);
    expect_read("rd44_glitch", 6, 54, 0);
    do_req(1'b0, 11'd8, 8'h00, 0);
    expect_read("rd8_cold", 6, 18, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between a CPU-side request port and the team's single-port byte RAM (`ramp`).
- Acts as the initiator on the RAM interface: it drives `addr`, `din` and `wr`, and samples the RAM's combinational `dout`.
- Holds data, tag and valid arrays internally. A read miss refills a whole line, one byte per cycle.

Parameters:
- DATA_WIDTH, 8, width of one data word (byte).
- ADDR_WIDTH, 11, byte address width; must match the RAM.
- INDEX_BITS, 3, line index width (8 lines).
- OFFSET_BITS, 2, word-in-line offset width (4 words per line).
- Derived TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS (6 at defaults).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request strobe; accepted only when cpu_ready=1.
- cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  ADDR_WIDTH  byte address; sampled with cpu_req.
- cpu_din  in  DATA_WIDTH  write data; sampled with cpu_req.
- cpu_ready  out  1  high only in IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_dout  out  DATA_WIDTH  read data, valid while cpu_done=1; held afterwards.
- cpu_hit  out  1  1 if the completed access hit; valid while cpu_done=1.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_din  out  DATA_WIDTH  RAM write data.
- mem_wr  out  1  RAM write enable.
- mem_dout  in  DATA_WIDTH  RAM read data, combinational from mem_addr.

Behaviour:
- Address split: tag = cpu_addr[ADDR_WIDTH-1 : INDEX_BITS+OFFSET_BITS], index = next INDEX_BITS bits, offset = low OFFSET_BITS bits.
- Reset (async):
  - All valid bits cleared; state = IDLE.
  - cpu_ready=1; cpu_done, cpu_hit, cpu_dout, mem_wr, mem_addr, mem_din all 0.
  - Data and tag arrays are not cleared.
- Acceptance: on an edge with cpu_req=1 in IDLE, latch cpu_wr/cpu_addr/cpu_din and go to LOOKUP. cpu_req outside IDLE is ignored; no queueing.
- LOOKUP (1 cycle): hit = valid[index] && tag[index] == latched tag.
  - Read hit: cpu_dout <= line word; cpu_hit <= 1; go to RESPOND.
  - Read miss: count <= 0; go to REFILL.
  - Write (hit or miss): go to WRITE; record hit.
- REFILL (2^OFFSET_BITS cycles):
  - mem_addr = {latched tag, index, count}; mem_wr=0.
  - Each edge writes mem_dout into line word[count] and increments count.
  - When the requested offset is written, also capture it into cpu_dout.
  - After the last word: valid[index] <= 1, tag[index] <= tag, cpu_hit <= 0, go to RESPOND.
- WRITE (1 cycle):
  - mem_addr = latched address, mem_din = latched data, mem_wr=1.
  - On a hit, also update the cached word. On a miss, the cache is unchanged (no allocate).
  - Then go to RESPOND.
- RESPOND (1 cycle): cpu_done=1, then go to IDLE; cpu_ready=1 in the following cycle.
- Latency, counted as cycles from the acceptance edge to the cpu_done-high cycle:
  - read hit: 2
  - read miss: 2 + 2^OFFSET_BITS (6 at defaults)
  - write: 3
- mem_wr is 1 only in WRITE, for exactly one cycle per write. mem_addr/mem_din are 0 in IDLE, LOOKUP and RESPOND.
- Reset mid-operation, including mid-REFILL:
  - Abort immediately; no cpu_done pulse.
  - The partially filled line stays invalid.
  - Any RAM write already issued stands.
- Back-to-back: a new request may be accepted on the first edge after the cpu_done cycle.

Test Plan:
- Reset the RAM (mem[a]=a+10 for a<62) and the controller; read addr 5 -> miss, mem_addr sweeps 4,5,6,7, cpu_done 6 cycles after acceptance with cpu_dout=15, cpu_hit=0.
- Then read addr 6 -> cpu_done after 2 cycles, cpu_dout=16, cpu_hit=1, mem_wr never asserted.
- Write addr 5 = 0xAA -> exactly one mem_wr pulse with mem_addr=5, mem_din=0xAA; cpu_done at 3 cycles with cpu_hit=1; next read of 5 hits with 0xAA, and RAM[5]=0xAA.
- Conflict (index 1): read 37 -> miss, 47; read 5 -> miss again, 0xAA (from RAM); read 37 -> miss, 47.
- Write miss to addr 40 = 0x55 -> cpu_hit=0 and no line allocated; read 40 -> miss, 0x55.
- Reset asserted in the 2nd REFILL cycle of a read of addr 20 -> no cpu_done, cpu_ready=1 at once; re-read of 20 -> miss (full 6-cycle refill), cpu_dout=30.
- cpu_req pulsed during REFILL -> ignored; exactly one cpu_done for the original request.
